// File: rtl/vdp_tiled.sv
// Tile-mode video display processor: sync timing, scrolled name/pattern fetch
// with per-tile flip, and a 4-entry 12-bit palette driving the VGA DAC pins.
module vdp_tiled #(
  parameter int unsigned H_ACTIVE      = 640,
  parameter int unsigned H_FP          = 16,
  parameter int unsigned H_SYNC        = 64,
  parameter int unsigned H_BP          = 120,
  parameter int unsigned V_ACTIVE      = 480,
  parameter int unsigned V_FP          = 1,
  parameter int unsigned V_SYNC        = 3,
  parameter int unsigned V_BP          = 16,
  parameter bit          SYNC_POL      = 1'b0,
  parameter int unsigned MAP_COLS_LOG2 = 6,
  parameter int unsigned MAP_ROWS_LOG2 = 6,
  parameter int unsigned BPP           = 2
) (
  input  logic                                   dot_clk,
  input  logic                                   reset_n,
  input  logic                                   reg_we,
  input  logic [2:0]                             reg_addr,
  input  logic [11:0]                            reg_wdata,
  output logic [MAP_ROWS_LOG2+MAP_COLS_LOG2-1:0] name_addr,
  input  logic [15:0]                            name_data,
  output logic [10:0]                            tile_addr,
  input  logic [8*BPP-1:0]                       tile_data,
  output logic [3:0]                             r,
  output logic [3:0]                             g,
  output logic [3:0]                             b,
  output logic                                   hsync,
  output logic                                   vsync,
  output logic                                   frame_start,
  output logic                                   vblank
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned CW      = $clog2(H_TOTAL);
  localparam int unsigned LW      = $clog2(V_TOTAL);
  localparam int unsigned SXW     = MAP_COLS_LOG2 + 3;
  localparam int unsigned SYW     = MAP_ROWS_LOG2 + 3;
  localparam int unsigned TDW     = 8 * BPP;

  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
    logic vb;
    logic fs;
  } flags_t;

  logic [CW-1:0]  col;
  logic [LW-1:0]  line;
  logic           col_last;
  logic           line_last;

  logic [SXW-1:0] sx_sh, sx_act, x;
  logic [SYW-1:0] sy_sh, sy_act, y;
  logic [11:0]    border;
  logic           enable;
  logic [11:0]    palette [4];

  flags_t         f1, f2, f3;
  logic [2:0]     s2_x, s2_y, s3_x, row, slot;
  logic           s3_hflip;
  logic [TDW-1:0] shifted;
  logic [1:0]     pix_idx;
  logic [11:0]    pix_colour;
  logic           unused_attr;

  assign col_last    = (col == CW'(H_TOTAL - 1));
  assign line_last   = (line == LW'(V_TOTAL - 1));
  assign unused_attr = ^name_data[7:2];

  // Dot and line counters
  always_ff @(posedge dot_clk or negedge reset_n) begin
    if (!reset_n) begin
      col  <= '0;
      line <= '0;
    end else if (col_last) begin
      col  <= '0;
      line <= line_last ? '0 : line + LW'(1);
    end else begin
      col  <= col + CW'(1);
    end
  end

  // Register file; scroll shadows are copied as the counters wrap to (0,0),
  // so a write on that same edge only reaches the following frame.
  always_ff @(posedge dot_clk or negedge reset_n) begin
    if (!reset_n) begin
      sx_sh      <= '0;
      sy_sh      <= '0;
      sx_act     <= '0;
      sy_act     <= '0;
      border     <= 12'h000;
      enable     <= 1'b1;
      palette[0] <= 12'h000;
      palette[1] <= 12'hF00;
      palette[2] <= 12'h0F0;
      palette[3] <= 12'hFF0;
    end else begin
      if (col_last && line_last) begin
        sx_act <= sx_sh;
        sy_act <= sy_sh;
      end
      if (reg_we) begin
        case (reg_addr)
          3'd0: sx_sh  <= reg_wdata[SXW-1:0];
          3'd1: sy_sh  <= reg_wdata[SYW-1:0];
          3'd2: border <= reg_wdata;
          3'd3: enable <= reg_wdata[0];
          default: begin
            if (BPP == 2 || !reg_addr[1]) palette[reg_addr[1:0]] <= reg_wdata;
          end
        endcase
      end
    end
  end

  // Stage 1: scrolled map coordinate, name fetch and timing flags
  always_comb begin
    x      = SXW'(col) + sx_act;
    y      = SYW'(line) + sy_act;
    f1.act = (32'(col) < H_ACTIVE) && (32'(line) < V_ACTIVE);
    f1.hs  = (32'(col) >= H_ACTIVE + H_FP) && (32'(col) < H_ACTIVE + H_FP + H_SYNC);
    f1.vs  = (32'(line) >= V_ACTIVE + V_FP) && (32'(line) < V_ACTIVE + V_FP + V_SYNC);
    f1.vb  = (32'(line) >= V_ACTIVE);
    f1.fs  = (col == '0) && (line == '0);
  end

  assign name_addr = {y[SYW-1:3], x[SXW-1:3]};

  // Stage 2: pattern row fetch with vertical flip
  assign row       = name_data[1] ? ~s2_y : s2_y;
  assign tile_addr = {name_data[15:8], row};

  // Stage 3: pixel select with horizontal flip
  always_comb begin
    slot       = s3_hflip ? ~s3_x : s3_x;
    shifted    = tile_data << (BPP * 32'(slot));
    pix_idx    = 2'(shifted[TDW-1 -: BPP]);
    pix_colour = enable ? palette[pix_idx] : border;
  end

  // Pipeline and output registers
  always_ff @(posedge dot_clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_x        <= '0;
      s2_y        <= '0;
      f2          <= '0;
      s3_x        <= '0;
      s3_hflip    <= 1'b0;
      f3          <= '0;
      {r, g, b}   <= 12'h000;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      frame_start <= 1'b0;
      vblank      <= 1'b0;
    end else begin
      s2_x        <= x[2:0];
      s2_y        <= y[2:0];
      f2          <= f1;
      s3_x        <= s2_x;
      s3_hflip    <= name_data[0];
      f3          <= f2;
      {r, g, b}   <= f3.act ? pix_colour : 12'h000;
      hsync       <= f3.hs ? SYNC_POL : ~SYNC_POL;
      vsync       <= f3.vs ? SYNC_POL : ~SYNC_POL;
      frame_start <= f3.fs;
      vblank      <= f3.vb;
    end
  end

endmodule

// File: tb/tb_vdp_tiled.sv
// Directed bench for vdp_tiled on a shrunken 48x10 raster so whole frames fit.
module tb_vdp_tiled;

  localparam int HT = 48;
  localparam int VT = 10;
  localparam int F  = HT * VT;

  logic        dot_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        reg_we = 1'b0;
  logic [2:0]  reg_addr = 3'd0;
  logic [11:0] reg_wdata = 12'h000;
  logic [11:0] name_addr;
  logic [15:0] name_data;
  logic [10:0] tile_addr;
  logic [15:0] tile_data;
  logic [3:0]  r, g, b;
  logic        hsync, vsync, frame_start, vblank;
  logic [11:0] rgb;

  logic [7:0]  m_name = 8'h01;
  logic [7:0]  m_attr = 8'h00;
  logic [15:0] m_pat  = 16'hE4E4;

  int vectors = 0;
  int miscompares = 0;
  int cyc;

  logic [11:0] def_pal  [4] = '{12'h000, 12'hF00, 12'h0F0, 12'hFF0};
  logic [11:0] flip_exp [8] = '{12'h000, 12'h000, 12'h000, 12'h000,
                                12'h000, 12'hF00, 12'h0F0, 12'hFF0};

  assign rgb = {r, g, b};

  vdp_tiled #(
    .H_ACTIVE(32), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b0), .MAP_COLS_LOG2(6), .MAP_ROWS_LOG2(6), .BPP(2)
  ) dut (
    .dot_clk(dot_clk), .reset_n(reset_n), .reg_we(reg_we), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .name_addr(name_addr), .name_data(name_data),
    .tile_addr(tile_addr), .tile_data(tile_data), .r(r), .g(g), .b(b),
    .hsync(hsync), .vsync(vsync), .frame_start(frame_start), .vblank(vblank)
  );

  always #5 dot_clk = ~dot_clk;

  // Edges since reset release: counter position is cyc mod F
  always @(posedge dot_clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  // Synchronous RAM models, one cycle read latency
  always @(posedge dot_clk) begin
    name_data <= {m_name, m_attr};
    tile_data <= m_pat;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic reg_write(input logic [2:0] a, input logic [11:0] d);
    reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    @(negedge dot_clk);
    reg_we = 1'b0;
  endtask

  task automatic wait_pos(input int pos);
    int n;
    n = 0;
    @(negedge dot_clk);
    while ((cyc % F) != pos && n < 2 * F) begin
      @(negedge dot_clk);
      n++;
    end
    vectors++;
    if ((cyc % F) != pos) begin
      miscompares++;
      $display("FAIL wait_pos: got pos %0d want %0d", cyc % F, pos);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge dot_clk);
    vectors += 5;
    if (rgb !== 12'h000) begin miscompares++; $display("FAIL rst_rgb: got %h want 000", rgb); end
    if (hsync !== 1'b1) begin miscompares++; $display("FAIL rst_hsync: got %b want 1", hsync); end
    if (vsync !== 1'b1) begin miscompares++; $display("FAIL rst_vsync: got %b want 1", vsync); end
    if (frame_start !== 1'b0) begin miscompares++; $display("FAIL rst_fs: got %b want 0", frame_start); end
    if (vblank !== 1'b0) begin miscompares++; $display("FAIL rst_vblank: got %b want 0", vblank); end
    reset_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge dot_clk);
      vectors++;
      if (frame_start !== (k == 3)) begin
        miscompares++;
        $display("FAIL rst_fs_cycle%0d: got %b want %b", k, frame_start, k == 3);
      end
      if (k == 3 || k == 5) begin
        vectors++;
        if (rgb !== ((k == 3) ? 12'hFF0 : 12'hF00)) begin
          miscompares++;
          $display("FAIL rst_pixel%0d: got %h want %h", k - 3, rgb, (k == 3) ? 12'hFF0 : 12'hF00);
        end
      end
    end
  endtask

  task automatic test_timing;
    int p, c, l, hs_low, vs_low, fs_cnt;
    logic e_hs, e_vs, e_vb, e_fs;
    logic [11:0] e_rgb;
    hs_low = 0; vs_low = 0; fs_cnt = 0;
    wait_pos(3);
    for (int i = 0; i < F; i++) begin
      p = (cyc - 3) % F; c = p % HT; l = p / HT;
      e_hs  = (c >= 36 && c < 44) ? 1'b0 : 1'b1;
      e_vs  = (l >= 7 && l < 9) ? 1'b0 : 1'b1;
      e_vb  = (l >= 6);
      e_fs  = (p == 0);
      e_rgb = (c < 32 && l < 6) ? def_pal[3 - (c % 4)] : 12'h000;
      vectors += 5;
      if (hsync !== e_hs) begin miscompares++; $display("FAIL hsync p=%0d: got %b want %b", p, hsync, e_hs); end
      if (vsync !== e_vs) begin miscompares++; $display("FAIL vsync p=%0d: got %b want %b", p, vsync, e_vs); end
      if (vblank !== e_vb) begin miscompares++; $display("FAIL vblank p=%0d: got %b want %b", p, vblank, e_vb); end
      if (frame_start !== e_fs) begin miscompares++; $display("FAIL frame_start p=%0d: got %b want %b", p, frame_start, e_fs); end
      if (rgb !== e_rgb) begin miscompares++; $display("FAIL pixel p=%0d: got %h want %h", p, rgb, e_rgb); end
      if (hsync === 1'b0) hs_low++;
      if (vsync === 1'b0) vs_low++;
      if (frame_start === 1'b1) fs_cnt++;
      @(negedge dot_clk);
    end
    vectors += 3;
    if (hs_low != 8 * VT) begin miscompares++; $display("FAIL hs_low_count: got %0d want %0d", hs_low, 8 * VT); end
    if (vs_low != 2 * HT) begin miscompares++; $display("FAIL vs_low_count: got %0d want %0d", vs_low, 2 * HT); end
    if (fs_cnt != 1) begin miscompares++; $display("FAIL fs_count: got %0d want 1", fs_cnt); end
  endtask

  task automatic test_scroll;
    wait_pos(100);
    reg_write(3'd0, 12'd509);
    wait_pos(144);
    vectors++;
    if (name_addr !== 12'd0) begin miscompares++; $display("FAIL scroll_shadow_hold: got %h want 000", name_addr); end
    wait_pos(0);
    vectors++;
    if (name_addr !== 12'd63) begin miscompares++; $display("FAIL scroll_col0: got %h want 03f", name_addr); end
    repeat (2) @(negedge dot_clk);
    vectors++;
    if (name_addr !== 12'd63) begin miscompares++; $display("FAIL scroll_col2: got %h want 03f", name_addr); end
    @(negedge dot_clk);
    vectors += 2;
    if (name_addr !== 12'd0) begin miscompares++; $display("FAIL scroll_wrap: got %h want 000", name_addr); end
    if (rgb !== 12'h0F0) begin miscompares++; $display("FAIL scroll_px0: got %h want 0f0", rgb); end
    repeat (3) @(negedge dot_clk);
    vectors++;
    if (rgb !== 12'hFF0) begin miscompares++; $display("FAIL scroll_px3: got %h want ff0", rgb); end
    // Write landing on the wrap edge must not reach this frame
    wait_pos(F - 1);
    reg_write(3'd0, 12'd0);
    vectors++;
    if (name_addr !== 12'd63) begin miscompares++; $display("FAIL scroll_copy_race: got %h want 03f", name_addr); end
    wait_pos(0);
    vectors++;
    if (name_addr !== 12'd0) begin miscompares++; $display("FAIL scroll_next_frame: got %h want 000", name_addr); end
    wait_pos(10);
    reg_write(3'd1, 12'd511);
    wait_pos(0);
    vectors++;
    if (name_addr !== 12'hFC0) begin miscompares++; $display("FAIL scroll_y_row: got %h want fc0", name_addr); end
    @(negedge dot_clk);
    vectors++;
    if (tile_addr !== 11'h00F) begin miscompares++; $display("FAIL scroll_y_tile: got %h want 00f", tile_addr); end
    wait_pos(48);
    vectors++;
    if (name_addr !== 12'd0) begin miscompares++; $display("FAIL scroll_y_wrap: got %h want 000", name_addr); end
    reg_write(3'd1, 12'd0);
  endtask

  task automatic test_flip;
    m_attr = 8'h03;
    m_pat  = 16'hE400;
    wait_pos(1);
    vectors++;
    if (tile_addr !== 11'h00F) begin miscompares++; $display("FAIL vflip_row7: got %h want 00f", tile_addr); end
    wait_pos(49);
    vectors++;
    if (tile_addr !== 11'h00E) begin miscompares++; $display("FAIL vflip_row6: got %h want 00e", tile_addr); end
    wait_pos(3);
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (rgb !== flip_exp[i]) begin
        miscompares++;
        $display("FAIL hflip_px%0d: got %h want %h", i, rgb, flip_exp[i]);
      end
      @(negedge dot_clk);
    end
    m_attr = 8'h00;
    m_pat  = 16'hE4E4;
  endtask

  task automatic test_border;
    int p, c, l;
    logic [11:0] e_rgb;
    reg_write(3'd2, 12'h00F);
    reg_write(3'd3, 12'h000);
    wait_pos(3);
    for (int i = 0; i < F; i++) begin
      p = (cyc - 3) % F; c = p % HT; l = p / HT;
      e_rgb = (c < 32 && l < 6) ? 12'h00F : 12'h000;
      vectors++;
      if (rgb !== e_rgb) begin miscompares++; $display("FAIL border p=%0d: got %h want %h", p, rgb, e_rgb); end
      @(negedge dot_clk);
    end
    wait_pos(109);
    reg_we = 1'b1; reg_addr = 3'd2; reg_wdata = 12'h0A5;
    @(negedge dot_clk);
    reg_we = 1'b0;
    vectors++;
    if (rgb !== 12'h00F) begin miscompares++; $display("FAIL border_old: got %h want 00f", rgb); end
    @(negedge dot_clk);
    vectors++;
    if (rgb !== 12'h0A5) begin miscompares++; $display("FAIL border_new: got %h want 0a5", rgb); end
    reg_write(3'd3, 12'h001);
    reg_write(3'd2, 12'h000);
  endtask

  task automatic test_reset_mid;
    reg_write(3'd5, 12'h123);
    wait_pos(200);
    #2 reset_n = 1'b0;
    #1;
    vectors += 4;
    if (rgb !== 12'h000) begin miscompares++; $display("FAIL midrst_rgb: got %h want 000", rgb); end
    if (hsync !== 1'b1) begin miscompares++; $display("FAIL midrst_hsync: got %b want 1", hsync); end
    if (vsync !== 1'b1) begin miscompares++; $display("FAIL midrst_vsync: got %b want 1", vsync); end
    if (frame_start !== 1'b0) begin miscompares++; $display("FAIL midrst_fs: got %b want 0", frame_start); end
    repeat (2) @(negedge dot_clk);
    reset_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge dot_clk);
      vectors++;
      if (frame_start !== (k == 3)) begin
        miscompares++;
        $display("FAIL midrst_fs_cycle%0d: got %b want %b", k, frame_start, k == 3);
      end
    end
    vectors++;
    if (rgb !== 12'hF00) begin miscompares++; $display("FAIL midrst_palette: got %h want f00", rgb); end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_scroll();
    test_flip();
    test_border();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
